// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if: bundle between the E stage (master) and the MD sequencer (slave).
// Carries the op request (start/op/operands) and returns busy plus the HI/LO registers.
interface md_unit_ctrl_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_start, md_op, md_a, md_b,
    input  busy, hi, lo
  );

  modport slave (
    input  md_start, md_op, md_a, md_b,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer owning HI/LO.
// An accepted mult/div computes its 64-bit result immediately into a shadow
// register, holds busy for a fixed latency, then commits the shadow to {hi,lo}.
// Optional feature macro: MD_DIV_ZERO_GUARD_EN
//   defined   : divide by zero runs the full latency but leaves hi/lo unchanged
//   undefined : divide by zero commits lo = 32'hFFFF_FFFF, hi = dividend
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  md_unit_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [63:0]        shadow;

  logic               is_arith;
  logic [CNT_W-1:0]   run_len;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic [31:0]        mag_b_safe;
  logic [31:0]        uq;
  logic [31:0]        ur;
  logic [31:0]        quot;
  logic [31:0]        rem;
  logic [63:0]        result;

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Ops 0..3 are the arithmetic ones; op[1] selects divide vs multiply.
  assign is_arith = ~bus.md_op[2];
  assign run_len  = bus.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Signed divide works on magnitudes, so 0x80000000 / -1 never overflows a
  // host divider: magnitude 2^31 / 1, negated back, wraps to 0x80000000.
  assign a_neg      = (bus.md_op == OP_DIV) & bus.md_a[31];
  assign b_neg      = (bus.md_op == OP_DIV) & bus.md_b[31];
  assign mag_a      = a_neg ? -bus.md_a : bus.md_a;
  assign mag_b      = b_neg ? -bus.md_b : bus.md_b;
  assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq         = mag_a / mag_b_safe;
  assign ur         = mag_a % mag_b_safe;
  assign quot       = (a_neg ^ b_neg) ? -uq : uq;
  assign rem        = a_neg ? -ur : ur;

  // Select the 64-bit {hi,lo} result for the op being requested.
  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = '0;
    case (bus.md_op)
      3'd0: result = {{32{bus.md_a[31]}}, bus.md_a} * {{32{bus.md_b[31]}}, bus.md_b};
      3'd1: result = {32'd0, bus.md_a} * {32'd0, bus.md_b};
      3'd2, 3'd3: begin
        if (bus.md_b == 32'd0) begin
`ifdef MD_DIV_ZERO_GUARD_EN
          // hi/lo cannot change while RUN, so re-committing them is a no-op.
          result = {hi_q, lo_q};
`else
          result = {bus.md_a, 32'hFFFF_FFFF};
`endif
        end else begin
          result = {rem, quot};
        end
      end
      default: result = '0;
    endcase
  end

  // Sequencer FSM: accept in IDLE, count down in RUN, commit on the last busy cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      shadow <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.md_start) begin
            if (is_arith) begin
              shadow <= result;
              cnt    <= run_len;
              busy_q <= 1'b1;
              state  <= RUN;
            end else if (bus.md_op == OP_MTHI) begin
              hi_q <= bus.md_a;
            end else if (bus.md_op == OP_MTLO) begin
              lo_q <= bus.md_a;
            end
          end
        end
        RUN: begin
          // Any md_start here is ignored; the hazard unit is expected to stall.
          if (cnt == CNT_W'(1)) begin
            hi_q   <= shadow[63:32];
            lo_q   <= shadow[31:0];
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed and randomized checks of md_unit_ctrl against a
// behavioural model that computes results with 64-bit integer arithmetic.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_md_unit_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_ctrl_if bus ();

  md_unit_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  // Reference behaviour: busy length and resulting HI/LO for one accepted op.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    exp_t        e;
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    e.hi = cur_hi;
    e.lo = cur_lo;
    e.n  = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin
        sp = sa * sb;
        e.hi = sp[63:32]; e.lo = sp[31:0]; e.n = MULT_N;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32]; e.lo = up[31:0]; e.n = MULT_N;
      end
      3'd2, 3'd3: begin
        e.n = DIV_N;
        if (b == 32'd0) begin
`ifndef MD_DIV_ZERO_GUARD_EN
          e.hi = a; e.lo = 32'hFFFF_FFFF;
`endif
        end else if (op == 3'd2) begin
          sq = sa / sb; sr = sa % sb;
          e.hi = sr[31:0]; e.lo = sq[31:0];
        end else begin
          e.hi = a % b; e.lo = a / b;
        end
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  // Issue one op (called at a falling edge), count busy cycles, check HI/LO
  // in the first cycle busy is low. Returns at that falling edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    exp_t e;
    int   n;
    e = model(op, a, b, hi_m, lo_m);
    bus.md_start = 1'b1; bus.md_op = op; bus.md_a = a; bus.md_b = b;
    @(negedge clk);
    bus.md_start = 1'b0; bus.md_a = $urandom; bus.md_b = $urandom;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    tests_run++;
    if (n !== e.n) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, e.n);
    end
    tests_run++;
    if (bus.hi !== e.hi) begin
      tests_failed++;
      $display("FAIL %s hi: got %h expected %h", name, bus.hi, e.hi);
    end
    tests_run++;
    if (bus.lo !== e.lo) begin
      tests_failed++;
      $display("FAIL %s lo: got %h expected %h", name, bus.lo, e.lo);
    end
    hi_m = e.hi;
    lo_m = e.lo;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    // Reset wins over a simultaneous mthi.
    bus.md_start = 1'b1; bus.md_op = 3'd4; bus.md_a = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.md_start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0",
               bus.busy, bus.hi, bus.lo);
    end
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, "mult_7_m3");
    run_op(3'd1, 32'hFFFF_FFFF,  32'd2,         "multu_max_2");
    run_op(3'd2, 32'hFFFF_FFF9,  32'd2,         "div_m7_2");
    run_op(3'd3, 32'h8000_0000,  32'hFFFF_FFFF, "divu_big");
    run_op(3'd2, 32'h8000_0000,  32'hFFFF_FFFF, "div_overflow");
    run_op(3'd2, 32'd7,          32'hFFFF_FFFE, "div_7_m2");
  endtask

  task automatic test_mt();
    run_op(3'd4, 32'h1234_5678, 32'd0, "mthi");
    run_op(3'd5, 32'h0BAD_F00D, 32'd0, "mtlo");
    run_op(3'd6, 32'hFFFF_0000, 32'd5, "reserved6");
    run_op(3'd7, 32'h0000_FFFF, 32'd5, "reserved7");
  endtask

  // Starts during RUN (mtlo and a second mult) must not disturb the running op.
  task automatic test_ignore_while_busy();
    exp_t e;
    int   n;
    e = model(3'd0, 32'd3, 32'd4, hi_m, lo_m);
    bus.md_start = 1'b1; bus.md_op = 3'd0; bus.md_a = 32'd3; bus.md_b = 32'd4;
    @(negedge clk);
    bus.md_start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (n == 1) begin bus.md_start = 1'b1; bus.md_op = 3'd5; bus.md_a = 32'd1; end
      if (n == 2) begin bus.md_op = 3'd0; bus.md_a = 32'd9; bus.md_b = 32'd9; end
      if (n == 3) bus.md_start = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (n !== e.n) begin
      tests_failed++;
      $display("FAIL ignore_busy busy_cycles: got %0d expected %0d", n, e.n);
    end
    tests_run++;
    if (bus.hi !== e.hi || bus.lo !== e.lo) begin
      tests_failed++;
      $display("FAIL ignore_busy result: got %h_%h expected %h_%h", bus.hi, bus.lo, e.hi, e.lo);
    end
    hi_m = e.hi;
    lo_m = e.lo;
  endtask

  task automatic test_div_zero();
    run_op(3'd4, 32'h0000_00AA, 32'd0, "dz_set_hi");
    run_op(3'd5, 32'h0000_00BB, 32'd0, "dz_set_lo");
    run_op(3'd2, 32'd5,         32'd0, "div_by_zero");
    run_op(3'd3, 32'hF000_0001, 32'd0, "divu_by_zero");
  endtask

  task automatic test_back_to_back();
    // run_op returns in the first non-busy cycle, so each call starts there.
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "b2b_mult");
    run_op(3'd3, 32'd100,       32'd7,         "b2b_divu");
    run_op(3'd1, 32'h0001_0000, 32'h0001_0000, "b2b_multu");
    run_op(3'd4, 32'h5555_AAAA, 32'd0,         "b2b_mthi");
    run_op(3'd2, 32'hFFFF_FF9C, 32'd7,         "b2b_div");
  endtask

  task automatic test_reset_mid_run();
    run_op(3'd4, 32'h1111_1111, 32'd0, "rm_set_hi");
    run_op(3'd5, 32'h2222_2222, 32'd0, "rm_set_lo");
    bus.md_start = 1'b1; bus.md_op = 3'd2; bus.md_a = 32'd1000; bus.md_b = 32'd3;
    @(negedge clk);
    bus.md_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid busy_before: got %b expected 1", bus.busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid after: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    repeat (DIV_N + 4) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid no_commit: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    hi_m = '0;
    lo_m = '0;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: a = 32'h8000_0000;
        4: b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.md_start = 1'b0;
    bus.md_op    = 3'd0;
    bus.md_a     = '0;
    bus.md_b     = '0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_mt();
    test_ignore_while_busy();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
